neuron_requant: RTL and testbench

Output stage of the neuron datapath: accepts the 18-bit signed accumulator total produced by the bias adder and converts it to an 8-bit signed activation for the next layer. Applies optional ReLU, a rounding arithmetic right shift and saturation. Buffers results in a small FIFO behind a valid/ready handshake on both sides. Counts clipped samples for debug.

---
 rtl/neuron_pkg.sv | 10 +
 rtl/sync_fifo.sv | 66 ++++++
 rtl/neuron_requant.sv | 95 +++++++++
 tb/tb_neuron_requant.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// neuron_pkg: widths and types shared by the MAC, bias adder and requant stages.
package neuron_pkg;

   localparam int ACC_W = 18;
   localparam int ACT_W = 8;

   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic signed [ACT_W-1:0] act_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: generic single-clock FIFO. Pointers carry one extra MSB so that
// full and empty are told apart without a separate counter.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Next pointer values: clear wins over push and pop; push/pop are ignored when full/empty.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   // Pointer registers, dropped asynchronously on reset.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write at the tail.
   always_ff @(posedge clk) begin
      // NOTE: the array is not reset; stale contents are hidden by forcing rdata to 0 when empty.
      if (do_push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign level = wr_ptr_q - rd_ptr_q;
   assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/neuron_requant.sv
// neuron_requant: turns a signed accumulator total into a signed activation
// (optional ReLU, round-half-up arithmetic shift, saturation), queues it in a
// FIFO behind valid/ready, and counts clipped samples.
module neuron_requant
   import neuron_pkg::*;
#(
   parameter int IN_W    = ACC_W,
   parameter int OUT_W   = ACT_W,
   parameter int SHIFT   = 7,
   parameter int RELU_EN = 1,
   parameter int DEPTH   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_total,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic [7:0]              sat_count,
   output logic [$clog2(DEPTH):0]  level
);

   // One guard bit keeps the rounding add from overflowing.
   localparam int XW = IN_W + 1;
   localparam logic signed [XW-1:0] ROUND_BIAS = XW'(1) << (SHIFT - 1);
   localparam logic signed [XW-1:0] SAT_MAX    = XW'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [XW-1:0] SAT_MIN    = ~SAT_MAX;

   logic signed [XW-1:0]    x_ext, x_relu, x_round, r_shift;
   logic signed [OUT_W-1:0] act;
   logic                    sat;
   logic                    push, pop, full, empty;
   logic [7:0]              sat_count_q, sat_count_d;

   // Requantize the incoming total; ReLU zeroing is not counted as clipping.
   always_comb begin
      x_ext   = {in_total[IN_W-1], in_total};
      x_relu  = ((RELU_EN != 0) && x_ext[XW-1]) ? '0 : x_ext;
      x_round = x_relu + ROUND_BIAS;
      r_shift = x_round >>> SHIFT;
      sat     = 1'b0;
      act     = r_shift[OUT_W-1:0];
      if (r_shift > SAT_MAX) begin
         act = {1'b0, {(OUT_W-1){1'b1}}};
         sat = 1'b1;
      end else if (r_shift < SAT_MIN) begin
         act = {1'b1, {(OUT_W-1){1'b0}}};
         sat = 1'b1;
      end
   end

   // in_ready depends on registered state only, so a full FIFO never takes a push.
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && !full;
   assign pop       = out_ready && !empty;

   // Next clip count: clear wins, otherwise count clipped accepted samples, sticky at 255.
   always_comb begin
      sat_count_d = sat_count_q;
      if (clear) begin
         sat_count_d = '0;
      end else if (push && sat && (sat_count_q != 8'hFF)) begin
         sat_count_d = sat_count_q + 8'd1;
      end
   end

   // Clip counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sat_count_q <= '0;
      else     sat_count_q <= sat_count_d;
   end

   assign sat_count = sat_count_q;

   sync_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .push  (push),
      .pop   (pop),
      .wdata (act),
      .rdata (out_data),
      .full  (full),
      .empty (empty),
      .level (level)
   );

endmodule

// File: tb/tb_neuron_requant.sv
// tb_neuron_requant: two instances (ReLU on / ReLU off) checked by a
// scoreboard; expected activations are computed when a total is accepted and
// compared when the DUT hands the activation out.
module tb_neuron_requant;
   import neuron_pkg::*;

   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clear = 1'b0;
   logic out_ready = 1'b0;
   acc_t in_total = '0;
   logic [1:0] in_valid = '0;

   logic              in_ready_v  [2];
   logic              out_valid_v [2];
   logic signed [7:0] out_data_v  [2];
   logic [7:0]        sat_v       [2];
   logic [LW-1:0]     level_v     [2];

   int n_checks = 0;
   int n_errors = 0;
   int q0 [$];
   int q1 [$];
   int exp_sat [2];

   always #5 clk = ~clk;

   // Instance 0: ReLU enabled.
   neuron_requant #(.IN_W(ACC_W), .OUT_W(ACT_W), .SHIFT(7), .RELU_EN(1), .DEPTH(DEPTH)) dut_relu (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid[0]), .in_ready(in_ready_v[0]), .in_total(in_total),
      .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_data(out_data_v[0]),
      .sat_count(sat_v[0]), .level(level_v[0])
   );

   // Instance 1: ReLU disabled, full signed path.
   neuron_requant #(.IN_W(ACC_W), .OUT_W(ACT_W), .SHIFT(7), .RELU_EN(0), .DEPTH(DEPTH)) dut_signed (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid[1]), .in_ready(in_ready_v[1]), .in_total(in_total),
      .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_data(out_data_v[1]),
      .sat_count(sat_v[1]), .level(level_v[1])
   );

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: ReLU, add half an LSB, floor-divide by 2^7, clip to 8 bits.
   function automatic int model(input int total, input bit relu, output bit sat);
      int v, q;
      v = total;
      if (relu && v < 0) v = 0;
      v = v + 64;
      q = v / 128;
      if (v < 0 && (v % 128) != 0) q = q - 1;
      sat = 1'b0;
      if (q > 127) begin
         q = 127;
         sat = 1'b1;
      end else if (q < -128) begin
         q = -128;
         sat = 1'b1;
      end
      return q;
   endfunction

   function automatic int qsize(input int s);
      return (s == 0) ? q0.size() : q1.size();
   endfunction

   task automatic flush(input int s);
      if (s == 0) q0.delete(); else q1.delete();
      exp_sat[s] = 0;
   endtask

   // Scoreboard step for one instance; runs on the falling edge, so it sees
   // the handshake that the next rising edge will complete.
   task automatic mon(input int s);
      int e;
      bit sat;
      if (rst) begin
         flush(s);
         return;
      end
      check($sformatf("level%0d", s), level_v[s], qsize(s));
      check($sformatf("sat_count%0d", s), sat_v[s], exp_sat[s]);
      check($sformatf("out_valid%0d", s), out_valid_v[s], qsize(s) != 0);
      check($sformatf("in_ready%0d", s), in_ready_v[s], qsize(s) < DEPTH);
      if (clear) begin
         flush(s);
         return;
      end
      if (out_valid_v[s] && out_ready) begin
         if (qsize(s) == 0) begin
            check($sformatf("sb_underflow%0d", s), 1, 0);
         end else begin
            e = (s == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("out_data%0d", s), out_data_v[s], e);
         end
      end
      if (in_valid[s] && in_ready_v[s]) begin
         e = model(in_total, s == 0, sat);
         if (s == 0) q0.push_back(e); else q1.push_back(e);
         if (sat && exp_sat[s] < 255) exp_sat[s]++;
      end
   endtask

   always @(negedge clk) begin
      for (int s = 0; s < 2; s++) mon(s);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int s, input int val);
      in_total    = acc_t'(val);
      in_valid[s] = 1'b1;
      step();
      in_valid[s] = 1'b0;
   endtask

   task automatic drain(input int s);
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (!out_valid_v[s]) break;
         step();
      end
      check($sformatf("drain%0d", s), out_valid_v[s], 0);
   endtask

   task automatic check_reset_values(input string tag);
      for (int s = 0; s < 2; s++) begin
         check($sformatf("%s_in_ready%0d", tag, s), in_ready_v[s], 1);
         check($sformatf("%s_out_valid%0d", tag, s), out_valid_v[s], 0);
         check($sformatf("%s_out_data%0d", tag, s), out_data_v[s], 0);
         check($sformatf("%s_sat%0d", tag, s), sat_v[s], 0);
         check($sformatf("%s_level%0d", tag, s), level_v[s], 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int vals [5];
      vals = '{1280, 2560, 3840, 5120, 6400};

      // Reset state.
      repeat (3) step();
      check_reset_values("reset");
      rst = 1'b0;
      step();

      // Rounding with ReLU, one-cycle latency.
      out_ready = 1'b1;
      send(0, 1000);
      check("lat_valid", out_valid_v[0], 1);
      check("lat_data", out_data_v[0], 8);
      in_total = acc_t'(64);
      in_valid[0] = 1'b1;
      step();
      check("round_64", out_data_v[0], 1);
      in_total = acc_t'(63);
      step();
      check("round_63", out_data_v[0], 0);
      in_valid[0] = 1'b0;
      drain(0);
      check("round_sat", sat_v[0], 0);

      // Saturation with ReLU.
      send(0, 20000);
      check("sat_20000", out_data_v[0], 127);
      check("sat_cnt1", sat_v[0], 1);
      send(0, 131071);
      check("sat_max", out_data_v[0], 127);
      check("sat_cnt2", sat_v[0], 2);
      send(0, -500);
      check("relu_neg", out_data_v[0], 0);
      check("relu_no_sat", sat_v[0], 2);
      drain(0);

      // Signed path without ReLU.
      send(1, -500);
      check("neg_500", out_data_v[1], -4);
      send(1, -64);
      check("neg_64", out_data_v[1], 0);
      send(1, -65);
      check("neg_65", out_data_v[1], -1);
      send(1, -131072);
      check("neg_min", out_data_v[1], -128);
      check("neg_sat", sat_v[1], 1);
      drain(1);

      // Backpressure: fill, stall, then release.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_total = acc_t'(vals[i]);
         in_valid[0] = 1'b1;
         step();
      end
      check("bp_in_ready", in_ready_v[0], 0);
      check("bp_level", level_v[0], 4);
      in_total = acc_t'(vals[4]);
      for (int i = 0; i < 2; i++) begin
         step();
         check("bp_stable", out_data_v[0], 10);
         check("bp_level_hold", level_v[0], 4);
      end
      out_ready = 1'b1;
      step();
      check("full_pop_ready", in_ready_v[0], 1);
      check("full_pop_level", level_v[0], 3);
      step();
      check("refill_level", level_v[0], 3);
      in_valid[0] = 1'b0;
      drain(0);

      // Push and pop together at level 2.
      out_ready = 1'b0;
      send(0, 128);
      send(0, 256);
      check("mid_level", level_v[0], 2);
      in_total = acc_t'(384);
      in_valid[0] = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid[0] = 1'b0;
      check("pushpop_level", level_v[0], 2);
      drain(0);

      // Clear with entries queued and a nonzero clip count.
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clr0_sat", sat_v[0], 0);
      send(0, 20000);
      send(0, -131072 + 131071 + 30000);
      drain(0);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(0, 50000 + i);
      check("pre_clr_level", level_v[0], 3);
      check("pre_clr_sat", sat_v[0], 5);
      clear = 1'b1;
      in_total = acc_t'(1000);
      in_valid[0] = 1'b1;
      out_ready = 1'b1;
      step();
      clear = 1'b0;
      in_valid[0] = 1'b0;
      check("clr_level", level_v[0], 0);
      check("clr_valid", out_valid_v[0], 0);
      check("clr_sat", sat_v[0], 0);
      check("clr_in_ready", in_ready_v[0], 1);

      // Asynchronous reset mid-burst.
      out_ready = 1'b0;
      send(0, 20000);
      send(0, 20000);
      send(1, -131072);
      check("pre_rst_level", level_v[0], 2);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_reset_values("async_rst");
      step();
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      send(0, 1000);
      check("post_rst_data", out_data_v[0], 8);
      drain(0);
      drain(1);
      check("sb_empty0", q0.size(), 0);
      check("sb_empty1", q1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
